phase_controller: RTL and testbench

PHASE_CONTROLLER -- requirements
Module: phase_controller

---
 rtl/simple_pkg.sv | 55 +++++
 rtl/instr_field_decode.sv | 46 ++++
 rtl/phase_controller.sv | 174 +++++++++++++++++
 tb/tb_phase_controller.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/simple_pkg.sv
// Shared encodings for the phase controller: phase numbering, instruction
// field constants and the ALU opcode map.
package simple_pkg;

  // Controller phase encoding; the numeric values are visible on the phase port.
  typedef enum logic [2:0] {
    PH_IDLE = 3'd0,
    PH_IF   = 3'd1,
    PH_ID   = 3'd2,
    PH_EX   = 3'd3,
    PH_MEM  = 3'd4,
    PH_WB   = 3'd5,
    PH_HALT = 3'd6
  } phase_e;

  // op1 field (ir[15:14]): major instruction class.
  localparam logic [1:0] OP1_LD  = 2'b00;
  localparam logic [1:0] OP1_ST  = 2'b01;
  localparam logic [1:0] OP1_IMM = 2'b10;
  localparam logic [1:0] OP1_ALU = 2'b11;

  // op2 field (ir[13:11]) under op1 = OP1_IMM.
  localparam logic [2:0] OP2_LI    = 3'b000;
  localparam logic [2:0] OP2_ADDI  = 3'b001;
  localparam logic [2:0] OP2_CMPI  = 3'b010;
  localparam logic [2:0] OP2_RSV3  = 3'b011;
  localparam logic [2:0] OP2_B     = 3'b100;
  localparam logic [2:0] OP2_RSV5  = 3'b101;
  localparam logic [2:0] OP2_RSV6  = 3'b110;
  localparam logic [2:0] OP2_BCOND = 3'b111;

  // ALU opcode field (ir[7:4]) under op1 = OP1_ALU.
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_CMP  = 4'd5;
  localparam logic [3:0] ALU_MOV  = 4'd6;
  localparam logic [3:0] ALU_RSV7 = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SLR  = 4'd9;
  localparam logic [3:0] ALU_SRL  = 4'd10;
  localparam logic [3:0] ALU_SRA  = 4'd11;
  localparam logic [3:0] ALU_IN   = 4'd12;
  localparam logic [3:0] ALU_OUT  = 4'd13;
  localparam logic [3:0] ALU_RSV  = 4'd14;
  localparam logic [3:0] ALU_HLT  = 4'd15;

  // Shift opcodes 8..11 behave like arithmetic ops for flags and write-back.
  function automatic logic is_shift_op(input logic [3:0] opcode);
    return (opcode >= ALU_SLL) && (opcode <= ALU_SRA);
  endfunction

endpackage

// File: rtl/instr_field_decode.sv
// Combinational instruction class decode from the op1/op2/opcode fields.
module instr_field_decode
  import simple_pkg::*;
(
  input  logic [1:0] op1,
  input  logic [2:0] op2,
  input  logic [3:0] opcode,
  output logic       is_flagset,
  output logic       is_regwrite,
  output logic       is_load,
  output logic       is_store,
  output logic       is_branch,
  output logic       is_halt
);

  // Classify the instruction; unlisted encodings fall through to all-zero.
  always_comb begin
    is_flagset  = 1'b0;
    is_regwrite = 1'b0;
    is_load     = 1'b0;
    is_store    = 1'b0;
    is_branch   = 1'b0;
    is_halt     = 1'b0;
    case (op1)
      OP1_LD: begin
        is_load     = 1'b1;
        is_regwrite = 1'b1;
      end
      OP1_ST: begin
        is_store = 1'b1;
      end
      OP1_IMM: begin
        is_flagset  = (op2 == OP2_ADDI) || (op2 == OP2_CMPI);
        is_regwrite = (op2 == OP2_LI) || (op2 == OP2_ADDI);
        is_branch   = (op2 == OP2_B) || (op2 == OP2_BCOND);
      end
      default: begin
        // CMP sets flags but produces no register result.
        is_flagset  = (opcode <= ALU_MOV) || is_shift_op(opcode);
        is_regwrite = ((opcode <= ALU_MOV) && (opcode != ALU_CMP)) || is_shift_op(opcode);
        is_halt     = (opcode == ALU_HLT);
      end
    endcase
  end

endmodule

// File: rtl/phase_controller.sv
// Multi-cycle control sequencer: IF -> ID -> EX -> MEM -> WB with memory
// wait states, flag latching, write-back/PC strobes and an absorbing HALT.
module phase_controller
  import simple_pkg::*;
#(
  parameter int XLEN = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] instr,
  input  logic            mem_ready,
  input  logic            alu_s,
  input  logic            alu_z,
  input  logic            alu_c,
  input  logic            alu_v,
  input  logic            alu_hlt,
  output logic            mem_req,
  output logic            mem_we,
  output logic            mem_addr_sel,
  output logic [XLEN-1:0] ir,
  output logic [2:0]      ra_addr,
  output logic [2:0]      rb_addr,
  output logic [1:0]      alu_op1,
  output logic [2:0]      alu_op2,
  output logic [2:0]      alu_cond,
  output logic [3:0]      alu_opcode,
  output logic [3:0]      alu_d,
  output logic            flag_s,
  output logic            flag_z,
  output logic            flag_c,
  output logic            flag_v,
  output logic            dr_we,
  output logic            mdr_we,
  output logic            reg_we,
  output logic            wb_sel,
  output logic [2:0]      wb_addr,
  output logic            pc_inc,
  output logic            pc_load,
  output logic [2:0]      phase,
  output logic            halted
);

  phase_e          state_reg, state_next;
  logic [XLEN-1:0] ir_reg;
  logic [3:0]      flags_reg;   // {s, z, c, v}

  logic is_flagset, is_regwrite, is_load, is_store, is_branch, is_halt;

  // Field outputs are straight slices of the instruction register, so they
  // are valid from ID onward without further staging.
  assign ir         = ir_reg;
  assign alu_op1    = ir_reg[15:14];
  assign alu_op2    = ir_reg[13:11];
  assign alu_cond   = ir_reg[10:8];
  assign alu_opcode = ir_reg[7:4];
  assign alu_d      = ir_reg[3:0];
  assign ra_addr    = ir_reg[13:11];
  assign rb_addr    = ir_reg[10:8];

  assign {flag_s, flag_z, flag_c, flag_v} = flags_reg;

  assign phase  = state_reg;
  assign halted = (state_reg == PH_HALT);

  // Loads write the register named by ir[13:11] from MDR; everything else
  // writes ir[10:8] from DR.
  assign wb_sel  = is_load;
  assign wb_addr = is_load ? ir_reg[13:11] : ir_reg[10:8];

  instr_field_decode u_decode (
    .op1         (ir_reg[15:14]),
    .op2         (ir_reg[13:11]),
    .opcode      (ir_reg[7:4]),
    .is_flagset  (is_flagset),
    .is_regwrite (is_regwrite),
    .is_load     (is_load),
    .is_store    (is_store),
    .is_branch   (is_branch),
    .is_halt     (is_halt)
  );

  // State, instruction and flag registers; reset abandons any pending access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= PH_IDLE;
      ir_reg    <= '0;
      flags_reg <= '0;
    end else begin
      state_reg <= state_next;
      if ((state_reg == PH_IF) && mem_ready) begin
        ir_reg <= instr;
      end
      if ((state_reg == PH_EX) && is_flagset) begin
        flags_reg <= {alu_s, alu_z, alu_c, alu_v};
      end
    end
  end

  // Next-state selection and per-phase strobes; strobes are forced low in reset.
  always_comb begin
    state_next   = state_reg;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    dr_we        = 1'b0;
    mdr_we       = 1'b0;
    reg_we       = 1'b0;
    pc_inc       = 1'b0;
    pc_load      = 1'b0;
    case (state_reg)
      PH_IDLE: begin
        state_next = PH_IF;
      end
      PH_IF: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          state_next = PH_ID;
        end
      end
      PH_ID: begin
        state_next = PH_EX;
      end
      PH_EX: begin
        dr_we = 1'b1;
        // A halt that the ALU confirms skips MEM and WB entirely.
        if (is_halt && alu_hlt) begin
          state_next = PH_HALT;
        end else begin
          state_next = PH_MEM;
        end
      end
      PH_MEM: begin
        if (is_load || is_store) begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = is_store;
          if (mem_ready) begin
            mdr_we     = is_load;
            state_next = PH_WB;
          end
        end else begin
          state_next = PH_WB;
        end
      end
      PH_WB: begin
        reg_we = is_regwrite;
        // Branch direction is already folded into DR by the ALU.
        if (is_branch) begin
          pc_load = 1'b1;
        end else begin
          pc_inc = 1'b1;
        end
        state_next = PH_IF;
      end
      PH_HALT: begin
        state_next = PH_HALT;
      end
      default: begin
        state_next = PH_IDLE;
      end
    endcase
    if (rst) begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      dr_we        = 1'b0;
      mdr_we       = 1'b0;
      reg_we       = 1'b0;
      pc_inc       = 1'b0;
      pc_load      = 1'b0;
    end
  end

endmodule

// File: tb/tb_phase_controller.sv
// Directed test of the phase controller: ADD, CMP, LD with wait states,
// IF wait, branch, store, halt and reset out of HALT and an IF wait.
module tb_phase_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr;
  logic        mem_ready;
  logic        alu_s, alu_z, alu_c, alu_v, alu_hlt;
  logic        mem_req, mem_we, mem_addr_sel;
  logic [15:0] ir;
  logic [2:0]  ra_addr, rb_addr;
  logic [1:0]  alu_op1;
  logic [2:0]  alu_op2, alu_cond;
  logic [3:0]  alu_opcode, alu_d;
  logic        flag_s, flag_z, flag_c, flag_v;
  logic        dr_we, mdr_we, reg_we, wb_sel;
  logic [2:0]  wb_addr;
  logic        pc_inc, pc_load;
  logic [2:0]  phase;
  logic        halted;

  int n_assert = 0;
  int n_fail   = 0;

  // strobe vector order: mem_req, mem_we, dr_we, mdr_we, reg_we, pc_inc, pc_load
  logic [6:0] strobes;
  logic [3:0] flags;
  assign strobes = {mem_req, mem_we, dr_we, mdr_we, reg_we, pc_inc, pc_load};
  assign flags   = {flag_s, flag_z, flag_c, flag_v};

  always #5 clk = ~clk;

  phase_controller #(.XLEN(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr        (instr),
    .mem_ready    (mem_ready),
    .alu_s        (alu_s),
    .alu_z        (alu_z),
    .alu_c        (alu_c),
    .alu_v        (alu_v),
    .alu_hlt      (alu_hlt),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .ir           (ir),
    .ra_addr      (ra_addr),
    .rb_addr      (rb_addr),
    .alu_op1      (alu_op1),
    .alu_op2      (alu_op2),
    .alu_cond     (alu_cond),
    .alu_opcode   (alu_opcode),
    .alu_d        (alu_d),
    .flag_s       (flag_s),
    .flag_z       (flag_z),
    .flag_c       (flag_c),
    .flag_v       (flag_v),
    .dr_we        (dr_we),
    .mdr_we       (mdr_we),
    .reg_we       (reg_we),
    .wb_sel       (wb_sel),
    .wb_addr      (wb_addr),
    .pc_inc       (pc_inc),
    .pc_load      (pc_load),
    .phase        (phase),
    .halted       (halted)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; instr = 16'h0000; mem_ready = 1'b0;
    alu_s = 1'b0; alu_z = 1'b0; alu_c = 1'b0; alu_v = 1'b0; alu_hlt = 1'b0;
    tick(); tick();
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_ir", 32'(ir), 32'h0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_flags", 32'(flags), 32'h0);
    chk("rst_strobes", 32'(strobes), 32'h0);

    // ADD R1,R2
    rst = 1'b0; instr = 16'hD100; mem_ready = 1'b1;
    tick();
    chk("add_if_phase", 32'(phase), 32'd1);
    chk("add_if_strobes", 32'(strobes), 32'b1000000);
    chk("add_if_addrsel", 32'(mem_addr_sel), 32'd0);
    tick();
    chk("add_id_phase", 32'(phase), 32'd2);
    chk("add_id_ir", 32'(ir), 32'hD100);
    chk("add_id_fields", {alu_op1, alu_op2, alu_cond, alu_opcode, alu_d}, 32'b11_010_001_0000_0000);
    chk("add_id_regaddr", {ra_addr, rb_addr}, 32'b010_001);
    chk("add_id_strobes", 32'(strobes), 32'h0);
    tick();
    chk("add_ex_phase", 32'(phase), 32'd3);
    chk("add_ex_strobes", 32'(strobes), 32'b0010000);
    tick();
    chk("add_mem_phase", 32'(phase), 32'd4);
    chk("add_mem_strobes", 32'(strobes), 32'h0);
    tick();
    chk("add_wb_phase", 32'(phase), 32'd5);
    chk("add_wb_strobes", 32'(strobes), 32'b0000110);
    chk("add_wb_addr", 32'(wb_addr), 32'd1);
    chk("add_wb_sel", 32'(wb_sel), 32'd0);
    $display("txn ADD  0xD100 phase=%0d reg_we=%0b wb_addr=%0d", phase, reg_we, wb_addr);

    // CMP: flags latch z=1, c=1, s=0, v=0
    instr = 16'hD150; alu_z = 1'b1; alu_c = 1'b1;
    tick();
    chk("cmp_if_phase", 32'(phase), 32'd1);
    tick(); tick();
    tick();
    chk("cmp_mem_flags", 32'(flags), 32'b0110);
    tick();
    chk("cmp_wb_strobes", 32'(strobes), 32'b0000010);
    $display("txn CMP  0xD150 flags=%b reg_we=%0b", flags, reg_we);

    // LD R3 with three MEM wait cycles; ALU flags change but must not latch
    instr = 16'h1904; alu_z = 1'b0; alu_c = 1'b0; alu_s = 1'b1;
    tick(); tick(); tick();
    chk("ld_ex_phase", 32'(phase), 32'd3);
    mem_ready = 1'b0;
    tick();
    chk("ld_mem1_phase", 32'(phase), 32'd4);
    chk("ld_mem1_strobes", 32'(strobes), 32'b1000000);
    chk("ld_mem1_addrsel", 32'(mem_addr_sel), 32'd1);
    tick();
    chk("ld_mem2_phase", 32'(phase), 32'd4);
    tick();
    chk("ld_mem3_phase", 32'(phase), 32'd4);
    chk("ld_mem3_strobes", 32'(strobes), 32'b1000000);
    mem_ready = 1'b1;
    #1;
    chk("ld_mem4_strobes", 32'(strobes), 32'b1001000);
    chk("ld_mem4_phase", 32'(phase), 32'd4);
    tick();
    chk("ld_wb_phase", 32'(phase), 32'd5);
    chk("ld_wb_strobes", 32'(strobes), 32'b0000110);
    chk("ld_wb_sel", 32'(wb_sel), 32'd1);
    chk("ld_wb_addr", 32'(wb_addr), 32'd3);
    chk("ld_flags_kept", 32'(flags), 32'b0110);
    $display("txn LD   0x1904 wb_sel=%0b wb_addr=%0d", wb_sel, wb_addr);

    // BE with two IF wait cycles; flags must survive EX
    instr = 16'hB805; mem_ready = 1'b0;
    tick();
    chk("be_ifw1_phase", 32'(phase), 32'd1);
    chk("be_ifw1_req", 32'(mem_req), 32'd1);
    tick();
    chk("be_ifw2_phase", 32'(phase), 32'd1);
    chk("be_ifw2_ir", 32'(ir), 32'h1904);
    mem_ready = 1'b1; alu_s = 1'b1; alu_z = 1'b1; alu_c = 1'b1; alu_v = 1'b1;
    tick();
    chk("be_id_ir", 32'(ir), 32'hB805);
    tick(); tick();
    chk("be_mem_flags", 32'(flags), 32'b0110);
    tick();
    chk("be_wb_strobes", 32'(strobes), 32'b0000001);
    $display("txn BE   0xB805 pc_load=%0b pc_inc=%0b", pc_load, pc_inc);

    // ST: write request in MEM, no register write
    instr = 16'h4000; alu_s = 1'b0; alu_z = 1'b0; alu_c = 1'b0; alu_v = 1'b0;
    tick(); tick(); tick(); tick();
    chk("st_mem_strobes", 32'(strobes), 32'b1100000);
    chk("st_mem_addrsel", 32'(mem_addr_sel), 32'd1);
    tick();
    chk("st_wb_strobes", 32'(strobes), 32'b0000010);
    $display("txn ST   0x4000 done");

    // HLT confirmed by ALU
    instr = 16'hC0F0; alu_hlt = 1'b1;
    tick(); tick(); tick();
    chk("hlt_ex_phase", 32'(phase), 32'd3);
    tick();
    chk("hlt_phase", 32'(phase), 32'd6);
    chk("hlt_halted", 32'(halted), 32'd1);
    chk("hlt_strobes", 32'(strobes), 32'h0);
    for (int i = 0; i < 22; i++) begin
      mem_ready = i[0];
      tick();
      chk("hlt_hold", {29'd0, phase, 1'b0} | 32'(strobes != 7'd0), 32'd12);
    end
    $display("txn HLT  0xC0F0 halted=%0b", halted);

    // Reset out of HALT
    rst = 1'b1;
    tick();
    chk("rsth_phase", 32'(phase), 32'd0);
    chk("rsth_halted", 32'(halted), 32'd0);
    chk("rsth_ir", 32'(ir), 32'h0);

    // CMP setting s, then reset during an IF wait
    rst = 1'b0; instr = 16'hD150; mem_ready = 1'b1; alu_s = 1'b1; alu_hlt = 1'b0;
    tick(); tick(); tick(); tick();
    chk("cmp2_mem_flags", 32'(flags), 32'b1000);
    tick();
    instr = 16'h0000; mem_ready = 1'b0;
    tick(); tick();
    chk("ifw_phase", 32'(phase), 32'd1);
    chk("ifw_ir", 32'(ir), 32'hD150);
    rst = 1'b1;
    #1;
    chk("ifw_rst_req_now", 32'(mem_req), 32'd0);
    tick();
    chk("ifw_rst_phase", 32'(phase), 32'd0);
    chk("ifw_rst_ir", 32'(ir), 32'h0);
    chk("ifw_rst_flags", 32'(flags), 32'h0);
    chk("ifw_rst_req", 32'(mem_req), 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_if", 32'(phase), 32'd1);
    $display("txn RST  during IF wait phase=%0d", phase);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
